// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared core definitions: forwarding-select encodings, special register
// indices and the destination-tag entry tracked per post-ID stage.
package core_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam logic [3:0] PC_REG = 4'd15;
  localparam logic [3:0] LR_REG = 4'd14;

  // Tag destination field is sized for the widest register file we build;
  // narrower indices are zero-extended on insert and on compare.
  localparam int unsigned TAG_DST_W = 8;

  typedef struct packed {
    logic                 v;
    logic [TAG_DST_W-1:0] dst;
    logic                 we;
    logic                 ld;
  } tag_ent_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request / hazard-response bundle between the decode stage (master)
// and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_W   = 4,
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned STAGES  = 3,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned SW = $clog2(STAGES + 1);

  logic                       id_valid;
  logic [NUM_SRC*REG_W-1:0]   id_src;
  logic [NUM_SRC-1:0]         id_src_used;
  logic [REG_W-1:0]           id_dst;
  logic                       id_we;
  logic                       id_load;
  logic                       flush;
  logic [NUM_SRC*SW-1:0]      fwd_sel;
  logic                       pc_le;
  logic                       cu_nop;
  logic [CNT_W-1:0]           stall_cnt;

  modport master (
    output id_valid, id_src, id_src_used, id_dst, id_we, id_load, flush,
    input  fwd_sel, pc_le, cu_nop, stall_cnt
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_dst, id_we, id_load, flush,
    output fwd_sel, pc_le, cu_nop, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_src_match.sv
// Priority matcher for one ID source operand: picks the youngest tracked stage
// writing that register and flags a load whose data is not yet forwardable.
module hazard_src_match
  import core_pkg::*;
#(
  parameter int unsigned REG_W      = 4,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned PC_REG     = 15,
  parameter int unsigned SW         = 2
) (
  input  tag_ent_t [STAGES:1] ent,
  input  logic [REG_W-1:0]    src,
  input  logic                used,
  input  logic                id_valid,
  output logic [SW-1:0]       sel,
  output logic                hz
);

  logic gate_s;
  logic hit_s;

  // Oldest-to-youngest scan so the youngest hit is the one that sticks.
  always_comb begin
    gate_s = id_valid & used & (src != REG_W'(PC_REG));
    hit_s  = 1'b0;
    sel    = SW'(FWD_RF);
    hz     = 1'b0;
    for (int s = STAGES; s >= 1; s--) begin
      hit_s = gate_s & ent[s].v & ent[s].we & (ent[s].dst == TAG_DST_W'(src));
      sel   = hit_s ? SW'(s) : sel;
      hz    = hit_s ? (ent[s].ld & (s < int'(LOAD_READY))) : hz;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Forwarding and load-use hazard controller with its own shadow pipeline of
// destination tags, branch-flush squashing and a saturating stall counter.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned REG_W      = 4,
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned PC_REG     = int'(core_pkg::PC_REG),
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              R,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned SW = $clog2(STAGES + 1);

  tag_ent_t [STAGES:1]       ent_r;
  tag_ent_t                  ins_s;
  logic [CNT_W-1:0]          cnt_r;
  logic [SW-1:0]             sel_s [NUM_SRC];
  logic                      hz_s  [NUM_SRC];
  logic [NUM_SRC*SW-1:0]     fwd_sel_s;
  logic                      hz_any_s;
  logic                      stall_s;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    hazard_src_match #(
      .REG_W      (REG_W),
      .STAGES     (STAGES),
      .LOAD_READY (LOAD_READY),
      .PC_REG     (PC_REG),
      .SW         (SW)
    ) u_match (
      .ent      (ent_r),
      .src      (bus.id_src[k*REG_W +: REG_W]),
      .used     (bus.id_src_used[k]),
      .id_valid (bus.id_valid),
      .sel      (sel_s[k]),
      .hz       (hz_s[k])
    );
  end

  // Pack per-source selects and merge hazards; a flush overrides any stall.
  always_comb begin
    fwd_sel_s = '0;
    hz_any_s  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      fwd_sel_s[k*SW +: SW] = sel_s[k];
      hz_any_s              = hz_any_s | hz_s[k];
    end
    stall_s   = hz_any_s & ~bus.flush;
    ins_s.v   = bus.id_valid & bus.id_we & ~stall_s & ~bus.flush;
    ins_s.dst = TAG_DST_W'(bus.id_dst);
    ins_s.we  = bus.id_we;
    ins_s.ld  = bus.id_load;
  end

  // Advance the tag pipeline and count stall cycles.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      ent_r <= '0;
      cnt_r <= '0;
    end else begin
      ent_r[1] <= ins_s;
      for (int s = 2; s <= STAGES; s++) begin
        ent_r[s] <= ent_r[s-1];
      end
      if (stall_s && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign bus.fwd_sel   = fwd_sel_s;
  assign bus.pc_le     = ~stall_s;
  assign bus.cu_nop    = stall_s | bus.flush;
  assign bus.stall_cnt = cnt_r;

endmodule
